dot_mac_pipe: RTL and testbench

- Parametrised, fully pipelined multi-lane integer multiply-accumulate unit.
- Each launch computes the dot product of LANES operand pairs.
- The result either stands alone or is folded into a running accumulator, under per-operation control.
- Generalises the fixed 32-bit two-input multiplier and weighted-sum helpers used by generated HIR datapaths; it sits behind the scheduler's `t` strobe like the other arithmetic helpers.

---
 rtl/dot_mac_pipe.sv | 129 ++++++++++++
 tb/tb_dot_mac_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dot_mac_pipe.sv
// Pipelined multi-lane multiply-accumulate: registers operands, then lane products,
// then balancing stages, then a final sum/accumulate stage that registers the result.
module dot_mac_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LANES   = 2,
  parameter int unsigned LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   t,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic                   acc_en,
  input  logic                   acc_clr,
  output logic [WIDTH-1:0]       result,
  output logic                   result_valid,
  output logic                   busy
);

  if (LANES < 1 || LATENCY < 3) begin : g_param_check
    $error("dot_mac_pipe: LANES must be >= 1 and LATENCY must be >= 3");
  end

  // Product stage 2 plus LATENCY-3 balancing stages.
  localparam int unsigned NumProd = (LATENCY >= 3) ? LATENCY - 2 : 1;

  logic                   s1_valid_q;
  logic                   s1_en_q;
  logic                   s1_clr_q;
  logic [LANES*WIDTH-1:0] s1_a_q;
  logic [LANES*WIDTH-1:0] s1_b_q;

  logic [NumProd-1:0]                         pv_q;
  logic [NumProd-1:0]                         pen_q;
  logic [NumProd-1:0]                         pclr_q;
  logic [NumProd-1:0][LANES-1:0][WIDTH-1:0]   prod_q;
  logic [LANES-1:0][WIDTH-1:0]                prod_d;

  logic [WIDTH-1:0] dot;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_en_q    <= 1'b0;
      s1_clr_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= t;
      s1_en_q    <= t & acc_en;
      s1_clr_q   <= t & acc_clr;
      if (t) begin
        s1_a_q <= a;
        s1_b_q <= b;
      end
    end
  end

  always_comb begin
    prod_d = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = s1_a_q[i*WIDTH +: WIDTH] * s1_b_q[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q   <= '0;
      pen_q  <= '0;
      pclr_q <= '0;
      prod_q <= '0;
    end else begin
      pv_q[0]   <= s1_valid_q;
      pen_q[0]  <= s1_en_q;
      pclr_q[0] <= s1_clr_q;
      prod_q[0] <= prod_d;
      for (int k = 1; k < NumProd; k++) begin
        pv_q[k]   <= pv_q[k-1];
        pen_q[k]  <= pen_q[k-1];
        pclr_q[k] <= pclr_q[k-1];
        prod_q[k] <= prod_q[k-1];
      end
    end
  end

  always_comb begin
    dot = '0;
    for (int i = 0; i < LANES; i++) begin
      dot = dot + prod_q[NumProd-1][i];
    end
  end

  // Accumulator feedback closes within this stage, so consecutive ops chain without bubbles.
  always_comb begin
    acc_d    = acc_q;
    result_d = dot;
    unique case ({pen_q[NumProd-1], pclr_q[NumProd-1]})
      2'b10: begin
        acc_d    = acc_q + dot;
        result_d = acc_q + dot;
      end
      2'b11:   acc_d = dot;
      2'b01:   acc_d = '0;
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= pv_q[NumProd-1];
      if (pv_q[NumProd-1]) begin
        acc_q    <= acc_d;
        result_q <= result_d;
      end
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = s1_valid_q | (|pv_q);

endmodule

// File: tb/tb_dot_mac_pipe.sv
// Directed bench for dot_mac_pipe: a queue-based model checked every cycle, plus
// hand-computed literal results pinned to specific cycles.
module tb_dot_mac_pipe;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned LANES   = 2;
  localparam int unsigned LATENCY = 3;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   t = 1'b0;
  logic                   acc_en = 1'b0;
  logic                   acc_clr = 1'b0;
  logic [LANES*WIDTH-1:0] a = '0;
  logic [LANES*WIDTH-1:0] b = '0;
  logic [WIDTH-1:0]       result;
  logic                   result_valid;
  logic                   busy;

  dot_mac_pipe #(
    .WIDTH  (WIDTH),
    .LANES  (LANES),
    .LATENCY(LATENCY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .t           (t),
    .a           (a),
    .b           (b),
    .acc_en      (acc_en),
    .acc_clr     (acc_clr),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = -4;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               due;
    logic [WIDTH-1:0] dot;
    logic             en;
    logic             clr;
  } op_t;

  op_t              q[$];
  logic [WIDTH-1:0] m_acc = '0;
  logic [WIDTH-1:0] m_res = '0;
  logic [WIDTH-1:0] obs[int];
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] dot_of(input logic [LANES*WIDTH-1:0] x,
                                               input logic [LANES*WIDTH-1:0] y);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] xi, yi, p;
    s = '0;
    for (int i = 0; i < LANES; i++) begin
      xi = x[i*WIDTH +: WIDTH];
      yi = y[i*WIDTH +: WIDTH];
      p  = xi * yi;
      s  = s + p;
    end
    return s;
  endfunction

  // Reset discards everything in flight.
  always @(posedge rst) begin
    q.delete();
    m_acc = '0;
    m_res = '0;
  end

  always @(negedge clk) begin
    op_t  op;
    logic ev;
    if (rst) begin
      chk("rst_result", result, '0);
      chk("rst_valid", result_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      q.delete();
      m_acc = '0;
      m_res = '0;
    end else begin
      ev = 1'b0;
      if (q.size() != 0 && q[0].due == cyc) begin
        op = q.pop_front();
        ev = 1'b1;
        if (op.en && !op.clr) begin
          m_acc = m_acc + op.dot;
          m_res = m_acc;
        end else if (op.en && op.clr) begin
          m_acc = op.dot;
          m_res = op.dot;
        end else if (op.clr) begin
          m_acc = '0;
          m_res = op.dot;
        end else begin
          m_res = op.dot;
        end
      end
      chk("result_valid", result_valid, ev);
      chk("result", result, m_res);
      chk("busy", busy, q.size() != 0);
      if (result_valid) obs[cyc] = result;
      if (t) begin
        op.due = cyc + LATENCY;
        op.dot = dot_of(a, b);
        op.en  = acc_en;
        op.clr = acc_clr;
        q.push_back(op);
      end
    end
  end

  task automatic at_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input int n, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] a0,
                        input logic [WIDTH-1:0] b1, input logic [WIDTH-1:0] b0,
                        input logic en, input logic clr);
    at_cycle(n);
    a       = {a1, a0};
    b       = {b1, b0};
    acc_en  = en;
    acc_clr = clr;
    t       = 1'b1;
    @(posedge clk);
    #1;
    t       = 1'b0;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
  endtask

  int               lit_cyc[15] = '{13, 18, 28, 33, 34, 35, 36, 37, 38, 43, 44, 53, 54, 55, 64};
  logic [WIDTH-1:0] lit_val[15] = '{32'd31, 32'd50, 32'd9, 32'd1, 32'd3, 32'd6, 32'd10, 32'd100,
                                    32'd15, 32'hFFFF_FFFE, 32'd1, 32'd10, 32'd7, 32'd4, 32'd9};
  int               absent[4]   = '{11, 12, 14, 23};

  initial begin
    at_cycle(0);
    rst = 1'b0;

    launch(10, 32'd5, 32'd3, 32'd2, 32'd7, 1'b0, 1'b0);     // 3*7 + 5*2 = 31
    launch(15, 32'd0, 32'd10, 32'd0, 32'd5, 1'b1, 1'b1);    // acc = 50
    launch(20, 32'd0, 32'd2, 32'd0, 32'd3, 1'b1, 1'b0);     // killed by reset
    rst = 1'b1;
    #2;
    rst = 1'b0;
    launch(25, 32'd0, 32'd3, 32'd0, 32'd3, 1'b1, 1'b0);     // 9, acc was cleared

    launch(30, 32'd0, 32'd1, 32'd0, 32'd1, 1'b1, 1'b1);
    launch(31, 32'd0, 32'd1, 32'd0, 32'd2, 1'b1, 1'b0);
    launch(32, 32'd0, 32'd3, 32'd0, 32'd1, 1'b1, 1'b0);
    launch(33, 32'd0, 32'd2, 32'd0, 32'd2, 1'b1, 1'b0);
    launch(34, 32'd0, 32'd10, 32'd0, 32'd10, 1'b0, 1'b0);
    launch(35, 32'd3, 32'd2, 32'd1, 32'd1, 1'b1, 1'b0);     // 2 + 3 = 5 -> 15

    launch(40, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd2, 1'b1, 1'b1);
    launch(41, 32'd0, 32'd1, 32'd0, 32'd3, 1'b1, 1'b0);     // wraps to 1

    launch(50, 32'd0, 32'd5, 32'd0, 32'd2, 1'b1, 1'b1);
    launch(51, 32'd0, 32'd7, 32'd0, 32'd1, 1'b0, 1'b1);
    launch(52, 32'd0, 32'd2, 32'd0, 32'd2, 1'b1, 1'b0);

    // Controls with t low must not disturb the accumulator (still 4).
    at_cycle(60);
    a       = {$urandom(), $urandom()};
    b       = {$urandom(), $urandom()};
    acc_en  = 1'b0;
    acc_clr = 1'b1;
    launch(61, 32'd0, 32'd1, 32'd0, 32'd5, 1'b1, 1'b0);     // 4 + 5 = 9

    at_cycle(70);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("lit_c%0d", lit_cyc[i]),
          obs.exists(lit_cyc[i]) ? obs[lit_cyc[i]] : 'x, lit_val[i]);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("no_pulse_c%0d", absent[i]), obs.exists(absent[i]), 0);
    end
    chk("pulse_count", obs.size(), 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
